regfile_scoreboard: RTL and testbench

Parametrised register file for the MIPS pipeline, with two combinational read ports, one write-back port, qualified same-cycle write-through bypass, and an integrated scoreboard. The scoreboard tracks which registers have an in-flight writer. It sits in decode: it supplies operands and a stall/issue decision, and it clears its reservations when write-back retires. A flush input drops all reservations on branch or exception recovery.

---
 rtl/regfile_scoreboard.sv | 94 +++++++++
 tb/tb_regfile_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port, same-cycle
// write-through bypass and a busy-bit scoreboard that decides whether decode may issue.
module regfile_scoreboard #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_FILE_DEPTH = 32,
  parameter int REG_DIR_WIDTH  = 5,
  parameter bit ZERO_REG       = 1'b1,
  parameter bit BYPASS         = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_DIR_WIDTH-1:0] readr1,
  input  logic [REG_DIR_WIDTH-1:0] readr2,
  output logic [REG_WIDTH-1:0]     readd1,
  output logic [REG_WIDTH-1:0]     readd2,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [REG_DIR_WIDTH-1:0] issue_dest,
  output logic                     issue_ready,
  input  logic                     RegWrite,
  input  logic [REG_DIR_WIDTH-1:0] writer,
  input  logic [REG_WIDTH-1:0]     writedata,
  input  logic                     flush,
  output logic [REG_DIR_WIDTH:0]   busy_count
);

  logic [REG_WIDTH-1:0]      RegFile [REG_FILE_DEPTH];
  logic [REG_FILE_DEPTH-1:0] busy;
  logic [REG_FILE_DEPTH-1:0] busy_nxt;

  logic wr_en;
  logic byp1, byp2;
  logic src1_haz, src2_haz, waw_haz;
  logic fire, set_en, inc, dec;

  assign wr_en = RegWrite && !(ZERO_REG && (writer == '0));
  assign byp1  = BYPASS && RegWrite && (writer == readr1);
  assign byp2  = BYPASS && RegWrite && (writer == readr2);

  // A write-back to the destination releases the old reservation even without bypass,
  // so the write-after-write check ignores BYPASS.
  assign src1_haz = busy[readr1] && !byp1 && !(ZERO_REG && (readr1 == '0));
  assign src2_haz = busy[readr2] && !byp2 && !(ZERO_REG && (readr2 == '0));
  assign waw_haz  = issue_wen && busy[issue_dest] && !(RegWrite && (writer == issue_dest));

  assign issue_ready = !rst && !flush && !src1_haz && !src2_haz && !waw_haz;
  assign fire        = issue_valid && issue_ready;
  assign set_en      = fire && issue_wen && !(ZERO_REG && (issue_dest == '0));

  // Set is applied after clear so a same-register retire/reissue keeps the bit.
  assign inc = set_en && !busy[issue_dest];
  assign dec = RegWrite && busy[writer] && !(set_en && (issue_dest == writer));

  always_comb begin
    busy_nxt = busy;
    if (RegWrite) busy_nxt[writer] = 1'b0;
    if (set_en)   busy_nxt[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else if (flush) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy <= busy_nxt;
      if (inc && !dec)      busy_count <= busy_count + 1'b1;
      else if (dec && !inc) busy_count <= busy_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_FILE_DEPTH; i++) RegFile[i] <= '0;
    end else if (wr_en) begin
      RegFile[writer] <= writedata;
    end
  end

  always_comb begin
    readd1 = RegFile[readr1];
    if (byp1) readd1 = writedata;
    if ((ZERO_REG && (readr1 == '0)) || rst) readd1 = '0;
  end

  always_comb begin
    readd2 = RegFile[readr2];
    if (byp2) readd2 = writedata;
    if ((ZERO_REG && (readr2 == '0)) || rst) readd2 = '0;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed cycle table, reset/bypass-off sequences and
// randomized traffic compared against a set-based scoreboard model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  readr1, readr2, issue_dest, writer;
  logic        issue_valid, issue_wen, RegWrite, flush;
  logic [31:0] writedata;
  logic [31:0] readd1, readd2, nb_d1, nb_d2;
  logic        issue_ready, nb_ready;
  logic [5:0]  busy_count, nb_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .readr1(readr1), .readr2(readr2), .readd1(readd1), .readd2(readd2),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .RegWrite(RegWrite), .writer(writer), .writedata(writedata),
    .flush(flush), .busy_count(busy_count)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .readr1(readr1), .readr2(readr2), .readd1(nb_d1), .readd2(nb_d2),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dest(issue_dest),
    .issue_ready(nb_ready), .RegWrite(RegWrite), .writer(writer), .writedata(writedata),
    .flush(flush), .busy_count(nb_cnt)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv, iwen;
    logic [4:0]  dest, r1, r2;
    logic        fl;
    logic        e_rdy;
    logic [31:0] e_d1, e_d2;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference state: architectural register values and the set of reserved registers.
  logic [31:0] m_reg [32];
  bit          m_res [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rw, logic [4:0] wr, logic [31:0] wd, logic iv, logic iwen,
                              logic [4:0] dest, logic [4:0] r1, logic [4:0] r2, logic fl,
                              logic rdy, logic [31:0] d1, logic [31:0] d2, logic [5:0] cnt);
    vec_t v;
    v.rw = rw; v.wr = wr; v.wd = wd; v.iv = iv; v.iwen = iwen; v.dest = dest;
    v.r1 = r1; v.r2 = r2; v.fl = fl; v.e_rdy = rdy; v.e_d1 = d1; v.e_d2 = d2; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RegWrite = v.rw; writer = v.wr; writedata = v.wd; issue_valid = v.iv; issue_wen = v.iwen;
    issue_dest = v.dest; readr1 = v.r1; readr2 = v.r2; flush = v.fl;
  endtask

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWrite && writer == a) return writedata;
    return m_reg[a];
  endfunction

  function automatic logic m_ready();
    logic h1, h2, hw;
    h1 = m_res.exists(int'(readr1)) && !(RegWrite && writer == readr1);
    h2 = m_res.exists(int'(readr2)) && !(RegWrite && writer == readr2);
    hw = issue_wen && m_res.exists(int'(issue_dest)) && !(RegWrite && writer == issue_dest);
    return !flush && !h1 && !h2 && !hw;
  endfunction

  task automatic m_clear();
    m_res.delete();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    RegWrite = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(z);

    // Reset: a live write-back to a read address must not leak through.
    rst = 1'b1;
    RegWrite = 1'b1; writer = 5'd3; writedata = 32'hAAAA5555; readr1 = 5'd3; readr2 = 5'd3;
    #3;
    chk("rst_readd1", readd1, 0);
    chk("rst_readd2", readd2, 0);
    chk("rst_ready", issue_ready, 0);
    chk("rst_count", busy_count, 0);
    @(negedge clk);
    RegWrite = 1'b0; readr1 = 5'd0; readr2 = 5'd0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", issue_ready, 1);
    chk("post_rst_count", busy_count, 0);
    @(posedge clk);
    #1;

    //           rw wr  wd            iv iwen dest r1  r2  fl  rdy d1            d2      cnt
    tbl.push_back(mk(0, 0,  0,            0, 0, 0,  0,  0,  0, 1, 0,            0,      0));
    tbl.push_back(mk(0, 0,  0,            1, 1, 5,  0,  0,  0, 1, 0,            0,      0));
    tbl.push_back(mk(0, 0,  0,            1, 0, 0,  5,  0,  0, 0, 0,            0,      1));
    tbl.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0, 0,  5,  0,  0, 1, 32'hDEADBEEF, 0,      1));
    tbl.push_back(mk(0, 0,  0,            0, 0, 0,  5,  0,  0, 1, 32'hDEADBEEF, 0,      0));
    tbl.push_back(mk(1, 0,  32'h1234,     0, 0, 0,  0,  0,  0, 1, 0,            0,      0));
    tbl.push_back(mk(0, 0,  0,            1, 1, 0,  0,  0,  0, 1, 0,            0,      0));
    tbl.push_back(mk(0, 0,  0,            1, 1, 3,  0,  0,  0, 1, 0,            0,      0));
    tbl.push_back(mk(0, 0,  0,            1, 1, 7,  0,  0,  0, 1, 0,            0,      1));
    tbl.push_back(mk(0, 0,  0,            1, 1, 9,  0,  0,  0, 1, 0,            0,      2));
    tbl.push_back(mk(0, 0,  0,            1, 1, 12, 0,  0,  1, 0, 0,            0,      3));
    tbl.push_back(mk(0, 0,  0,            1, 1, 12, 12, 3,  0, 1, 0,            0,      0));
    tbl.push_back(mk(0, 0,  0,            1, 1, 4,  0,  0,  0, 1, 0,            0,      1));
    tbl.push_back(mk(1, 4,  32'h44,       1, 1, 4,  4,  0,  0, 1, 32'h44,       0,      2));
    tbl.push_back(mk(0, 0,  0,            1, 1, 4,  0,  0,  0, 0, 0,            0,      2));
    tbl.push_back(mk(1, 8,  32'h55,       0, 0, 0,  8,  0,  0, 1, 32'h55,       0,      2));
    tbl.push_back(mk(0, 0,  0,            0, 0, 0,  8,  4,  0, 0, 32'h55,       32'h44, 2));
    tbl.push_back(mk(1, 12, 32'h77,       0, 0, 0,  4,  12, 0, 0, 32'h44,       32'h77, 2));
    tbl.push_back(mk(0, 0,  0,            0, 0, 0,  12, 0,  0, 1, 32'h77,       0,      1));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), issue_ready, tbl[i].e_rdy);
      chk($sformatf("row%0d_readd1", i), readd1, tbl[i].e_d1);
      chk($sformatf("row%0d_readd2", i), readd2, tbl[i].e_d2);
      chk($sformatf("row%0d_count", i), busy_count, tbl[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a cycle, with register 4 busy and 8 holding data.
    drive(mk(1, 8, 32'h99, 0, 0, 0, 8, 4, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("pre_arst_bypass", readd1, 32'h99);
    chk("pre_arst_count", busy_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_readd1", readd1, 0);
    chk("arst_readd2", readd2, 0);
    chk("arst_ready", issue_ready, 0);
    chk("arst_count", busy_count, 0);
    chk("arst_nb_count", nb_cnt, 0);
    RegWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release_ready", issue_ready, 1);
    chk("arst_reg8_cleared", readd1, 0);
    @(posedge clk);
    #1;

    // Without bypass a write-back releases source hazards only from the next cycle.
    drive(mk(0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("nb_issue_ready", nb_ready, 1);
    @(posedge clk);
    #1;
    drive(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("nb_wb_ready", nb_ready, 0);
    chk("nb_wb_readd1", nb_d1, 0);
    chk("byp_wb_ready", issue_ready, 1);
    chk("byp_wb_readd1", readd1, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("nb_after_ready", nb_ready, 1);
    chk("nb_after_readd1", nb_d1, 32'hDEADBEEF);
    chk("nb_after_count", nb_cnt, 0);
    @(posedge clk);
    #1;

    // Randomized traffic on a narrow address range so hazards are frequent.
    pulse_reset();
    m_clear();
    for (int n = 0; n < 600; n++) begin
      logic       e_rdy;
      logic [4:0] d;
      RegWrite    = ($urandom % 3) == 0;
      writer      = 5'($urandom_range(0, 7));
      writedata   = $urandom;
      issue_valid = ($urandom % 4) != 0;
      issue_wen   = ($urandom % 3) != 0;
      issue_dest  = 5'($urandom_range(0, 7));
      readr1      = 5'($urandom_range(0, 7));
      readr2      = 5'($urandom_range(0, 7));
      flush       = ($urandom % 40) == 0;
      @(negedge clk);
      e_rdy = m_ready();
      chk("rnd_ready", issue_ready, e_rdy);
      chk("rnd_readd1", readd1, m_read(readr1));
      chk("rnd_readd2", readd2, m_read(readr2));
      chk("rnd_count", busy_count, m_res.num());
      if (flush) m_res.delete();
      else begin
        if (RegWrite) m_res.delete(int'(writer));
        if (issue_valid && e_rdy && issue_wen && issue_dest != 0) begin
          d = issue_dest;
          m_res[int'(d)] = 1'b1;
        end
      end
      if (RegWrite && writer != 0) m_reg[writer] = writedata;
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
